// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: bus width defaults and
// response-owner encodings.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_LS   = 2'd2
    } rsp_own_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority (load/store first) arbiter sharing one single-port RAM between the
// fetch and load/store ports, with a fetch starvation guard and 1-cycle read tracking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic                  clk,
    input  logic                  rest,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,

    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_W/8-1:0]   ls_be_i,
    input  logic [ADDR_W-1:0]     ls_addr_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_W-1:0]     ls_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int unsigned        CNT_W   = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_CONSEC);

    logic [CNT_W-1:0] r_consec_cnt;
    logic [CNT_W-1:0] w_consec_cnt_d;
    rsp_own_e         r_rsp_own;
    rsp_own_e         w_rsp_own_d;
    logic             w_fetch_starved;
    logic             w_ls_win;
    logic             w_if_win;

    // Compare uses the pre-increment count, so the grant that reaches the limit still
    // goes to load/store and fetch wins the cycle after.
    assign w_fetch_starved = if_req_i && (r_consec_cnt == CNT_MAX);
    assign w_ls_win        = rest && ls_req_i && !w_fetch_starved;
    assign w_if_win        = rest && if_req_i && !w_ls_win;

    assign if_gnt_o = w_if_win;
    assign ls_gnt_o = w_ls_win;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_ls_win) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_we_i ? ls_be_i : '1;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end else if (w_if_win) begin
            mem_en_o    = 1'b1;
            mem_be_o    = '1;
            mem_addr_o  = if_addr_i;
        end
    end

    always_comb begin
        w_consec_cnt_d = r_consec_cnt;
        if (!if_req_i || w_if_win) begin
            w_consec_cnt_d = '0;
        end else if (w_ls_win && (r_consec_cnt < CNT_MAX)) begin
            w_consec_cnt_d = r_consec_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rsp_own_d = RSP_NONE;
        if (w_if_win) begin
            w_rsp_own_d = RSP_IF;
        end else if (w_ls_win && !ls_we_i) begin
            w_rsp_own_d = RSP_LS;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_consec_cnt <= '0;
        end else begin
            r_consec_cnt <= w_consec_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_rsp_own <= RSP_NONE;
        end else begin
            r_rsp_own <= w_rsp_own_d;
        end
    end

    assign if_rvalid_o = (r_rsp_own == RSP_IF);
    assign ls_rvalid_o = (r_rsp_own == RSP_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

endmodule
